bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
- Downstream consumer of the combinational binary-to-BCD converter.
- Latches the three BCD digits (centenas, dezenas, unidades) on a load strobe into shadow registers.
- Time-multiplexes the digits onto a 3-digit common-anode 7-segment display using a programmable refresh divider.
- Flags non-BCD digit values.

Parameters:
- DIV_MAX, 50000: clocks per digit slot; legal range 1..2^CNT_W-1.
- CNT_W, 16: width of the refresh divider counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- carregar  input  1  load strobe; captures the digit inputs at the rising edge.
- centenas  input  4  BCD hundreds digit.
- dezenas  input  4  BCD tens digit.
- unidades  input  4  BCD units digit.
- anodos  output  3  digit enables, active-low one-hot; [0]=unidades, [1]=dezenas, [2]=centenas.
- segmentos  output  7  {g,f,e,d,c,b,a}, active-low.
- erro  output  1  high while any shadow digit is greater than 9.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: shadow digits=0, divider=0, scan state=DIG_U, anodos=3'b111, segmentos=7'b1111111, erro=0. Display stays dark until the first tick.
- Divider:
  - Counts 0..DIV_MAX-1 and wraps.
  - tick is high in the cycle where the count equals DIV_MAX-1, giving a period of DIV_MAX clocks.
  - With DIV_MAX=1, tick is high every cycle.
- Load:
  - carregar=1 at an edge captures all three inputs into the shadow registers.
  - erro updates at the same edge from the new values.
  - Back-to-back loads are allowed; the last one wins.
- Scan FSM:
  - States DIG_U -> DIG_D -> DIG_C -> DIG_U; advances only on tick.
  - At a tick edge the FSM moves to the next state. In the same edge anodos/segmentos are registered for that next state's digit.
  - The first tick after reset therefore shows dezenas (FSM leaves DIG_U).
- Outputs are fully registered and change only on tick edges.
- Decode uses shadow values as they were before the edge. A load coinciding with a tick shows the old digit in that slot; new values appear from the next tick.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = 'E' = 0000110
- Exactly one anodos bit is low whenever a digit is shown.
- Reset mid-scan: immediate return to reset values. The divider restarts from 0.

Optional Feature:
- Macro: BLANK_ZEROS_EN (leading-zero blanking).
- Defined:
  - Centenas slot is blanked when shadow centenas==0.
  - Dezenas slot is blanked when shadow centenas==0 and dezenas==0.
  - Unidades is never blanked; a digit greater than 9 is never blanked.
  - A blanked slot drives anodos=3'b111 and segmentos=7'b1111111. Scan timing is unchanged.
- Undefined: all three digits are always shown, zeros included.

Test Plan:
- Reset: hold rst_n=0, DIV_MAX=4 -> anodos=111, segmentos=1111111, erro=0. The values persist until the first tick, 4 clocks after release.
- Load and scan: DIV_MAX=4, carregar pulse with 1/2/3 (centenas/dezenas/unidades) -> successive ticks every 4 clocks give:
  - anodos=101 / segmentos=0100100
  - anodos=011 / segmentos=1111001
  - anodos=110 / segmentos=0110000
  - then repeat.
- Invalid digit: load dezenas=4'hA, centenas=0, unidades=5 -> erro=1 on the next edge. The dezenas slot shows 0000110. Reloading 0/0/5 clears erro.
- Simultaneous load and tick: load 9/9/9 on the tick cycle while showing 1/2/3 -> that slot shows the old digit; the next slot shows 0010000.
- Blanking with BLANK_ZEROS_EN: load 0/0/7 -> centenas and dezenas slots give anodos=111 / segmentos=1111111; unidades gives 110 / 1111000.
- Blanking without BLANK_ZEROS_EN: same load 0/0/7 -> the zero slots show 1000000.
- Mid-operation reset: assert rst_n=0 asynchronously mid-slot -> outputs go dark without waiting for clk. After release, scanning restarts from DIG_U with a full DIV_MAX delay.

Source files
------------

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: latches BCD digits and scans them onto a 3-digit common-anode display; `BLANK_ZEROS_EN enables leading-zero blanking
module bcd_display_scan #(
    parameter int DIV_MAX = 50000,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       carregar,
    input  logic [3:0] centenas,
    input  logic [3:0] dezenas,
    input  logic [3:0] unidades,
    output logic [2:0] anodos,
    output logic [6:0] segmentos,
    output logic       erro
);
    typedef enum logic [1:0] {DIG_U, DIG_D, DIG_C} state_t;
    state_t state, state_nxt, slot;
    logic [CNT_W-1:0] cnt;
    logic tick, blank;
    logic [3:0] c, d, u, dig;
    logic [2:0] an;
    logic [6:0] seg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0: decode = 7'b1000000;
            4'd1: decode = 7'b1111001;
            4'd2: decode = 7'b0100100;
            4'd3: decode = 7'b0110000;
            4'd4: decode = 7'b0011001;
            4'd5: decode = 7'b0010010;
            4'd6: decode = 7'b0000010;
            4'd7: decode = 7'b1111000;
            4'd8: decode = 7'b0000000;
            4'd9: decode = 7'b0010000;
            default: decode = 7'b0000110;
        endcase
    endfunction

    assign tick = cnt == CNT_W'(DIV_MAX - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= DIG_U;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            state <= state_nxt;
        end
    end

    // outputs are decoded for the slot being entered, from pre-edge shadow values
    always_comb begin
        slot = state == DIG_U ? DIG_D : state == DIG_D ? DIG_C : DIG_U;
        state_nxt = tick ? slot : state;
        dig = slot == DIG_D ? d : slot == DIG_C ? c : u;
`ifdef BLANK_ZEROS_EN
        blank = (slot == DIG_C && c == 4'd0) || (slot == DIG_D && c == 4'd0 && d == 4'd0);
`else
        blank = 1'b0;
`endif
        an = blank ? 3'b111 : slot == DIG_U ? 3'b110 : slot == DIG_D ? 3'b101 : 3'b011;
        seg = blank ? 7'b1111111 : decode(dig);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c    <= '0;
            d    <= '0;
            u    <= '0;
            erro <= 1'b0;
        end else if (carregar) begin
            c    <= centenas;
            d    <= dezenas;
            u    <= unidades;
            erro <= centenas > 4'd9 || dezenas > 4'd9 || unidades > 4'd9;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anodos    <= 3'b111;
            segmentos <= 7'b1111111;
        end else if (tick) begin
            anodos    <= an;
            segmentos <= seg;
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: random and directed stimulus against a slot-counting reference model
module tb_bcd_display_scan;
    localparam int DIV = 4;
    logic clk = 1'b0, rst_n = 1'b1, carregar = 1'b0;
    logic [3:0] centenas = '0, dezenas = '0, unidades = '0;
    logic [2:0] anodos;
    logic [6:0] segmentos;
    logic erro;
    int checks = 0, fails = 0;
    int cyc, slot;
    logic [3:0] sh [3];
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic e_err;
    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    bcd_display_scan #(.DIV_MAX(DIV), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .carregar(carregar), .centenas(centenas),
        .dezenas(dezenas), .unidades(unidades), .anodos(anodos),
        .segmentos(segmentos), .erro(erro)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("anodos", {5'd0, anodos}, {5'd0, e_an});
        check("segmentos", {1'b0, segmentos}, {1'b0, e_seg});
        check("erro", {7'd0, erro}, {7'd0, e_err});
    endtask

    task automatic model_reset();
        cyc = 0;
        slot = 0;
        for (int i = 0; i < 3; i++) sh[i] = 4'd0;
        e_an = 3'b111;
        e_seg = 7'h7f;
        e_err = 1'b0;
    endtask

    // slot 0 = unidades, 1 = dezenas, 2 = centenas; every DIV-th edge enters the next slot
    task automatic step(input logic ld, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        logic blank;
        carregar = ld;
        centenas = c;
        dezenas = d;
        unidades = u;
        @(posedge clk);
        if (cyc % DIV == DIV - 1) begin
            slot = (slot + 1) % 3;
            blank = 1'b0;
`ifdef BLANK_ZEROS_EN
            blank = (slot == 2 && sh[2] == 0) || (slot == 1 && sh[2] == 0 && sh[1] == 0);
`endif
            e_an = blank ? 3'b111 : ~(3'(1) << slot);
            e_seg = blank ? 7'h7f : tab[sh[slot]];
        end
        if (ld) begin
            sh[0] = u;
            sh[1] = d;
            sh[2] = c;
            e_err = c > 9 || d > 9 || u > 9;
        end
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
        idle(6);
        step(1'b1, 4'd1, 4'd2, 4'd3);
        idle(13);
        step(1'b1, 4'd0, 4'hA, 4'd5);
        idle(12);
        step(1'b1, 4'd0, 4'd0, 4'd5);
        idle(4);
        step(1'b1, 4'd1, 4'd2, 4'd3);
        while (cyc % DIV != DIV - 1) idle(1);
        step(1'b1, 4'd9, 4'd9, 4'd9);
        idle(8);
        step(1'b1, 4'd0, 4'd0, 4'd7);
        idle(12);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle(6);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0)
                step(1'b1,
                     $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15)),
                     $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
            else
                idle(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
